// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit driving a word-wide data memory port.
// Sub-word stores are done as read-modify-write (ACCESS reads, WRITE writes).
// Optional feature macro: DMEM_LSU_ALIGN_CHECK_EN
//   defined   -> misaligned half/word and size 11 return rsp_err_o=1, no write
//   undefined -> rsp_err_o=0, addresses aligned down, size 11 treated as word
//
// Handshake rules: a request transfers on a rising edge where req_valid_i and
// req_ready_o are both 1; a response transfers on a rising edge where
// rsp_valid_o and rsp_ready_i are both 1. The response holds its data until
// that transfer, and ready on either channel is ignored when valid is low.
module dmem_lsu #(
    parameter int N    = 32,
    parameter int ADDR = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [ADDR+1:0] req_addr_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [N-1:0]    req_wdata_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [N-1:0]    rsp_rdata_o,
    output logic            rsp_err_o,
    output logic [ADDR-1:0] dmem_addr_o,
    output logic [N-1:0]    dmem_st_data_o,
    output logic            dmem_st_en_o,
    input  logic [N-1:0]    dmem_ld_data_i,
    output logic [1:0]      dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WRITE  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t          state;
    state_t          next_state;

    logic            q_we;
    logic [1:0]      q_lane;
    logic [1:0]      q_size;
    logic            q_uns;
    logic            q_err;
    logic [N-1:0]    q_wdata;
    logic [ADDR-1:0] addr_q;
    logic [N-1:0]    merge_q;
    logic [N-1:0]    rdata_q;
    logic            err_q;

    logic [ADDR+1:0] cap_addr;
    logic [1:0]      cap_size;
    logic            cap_err;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [N-1:0]    ld_ext;
    logic [N-1:0]    merge;
    logic            st_en_raw;
    logic [N-1:0]    st_data;

    // Normalise the incoming request: flag errors, or align/legalise silently
    always_comb begin
        cap_addr = req_addr_i;
        cap_size = req_size_i;
        cap_err  = 1'b0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        cap_err = (req_size_i == 2'b11) ||
                  (req_size_i == SZ_HALF && req_addr_i[0]) ||
                  (req_size_i == SZ_WORD && req_addr_i[1:0] != 2'b00);
`else
        if (req_size_i == 2'b11) cap_size = SZ_WORD;
        if (cap_size == SZ_HALF) cap_addr[0] = 1'b0;
        if (cap_size == SZ_WORD) cap_addr[1:0] = 2'b00;
`endif
    end

    // Lane extraction and extension of the memory word for loads
    always_comb begin
        ld_byte = dmem_ld_data_i[8*q_lane +: 8];
        ld_half = q_lane[1] ? dmem_ld_data_i[31:16] : dmem_ld_data_i[15:0];
        case (q_size)
            SZ_BYTE: ld_ext = q_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = q_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
            default: ld_ext = dmem_ld_data_i;
        endcase
    end

    // Merge word for sub-word stores: current memory word with one lane replaced
    always_comb begin
        merge = dmem_ld_data_i;
        if (q_size == SZ_BYTE) merge[8*q_lane +: 8] = q_wdata[7:0];
        else if (q_size == SZ_HALF) merge[16*q_lane[1] +: 16] = q_wdata[15:0];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state and memory write strobe
    always_comb begin
        next_state = state;
        st_en_raw  = 1'b0;
        st_data    = '0;
        case (state)
            S_IDLE: begin
                if (req_valid_i) next_state = S_ACCESS;
            end
            S_ACCESS: begin
                if (q_err || !q_we) begin
                    next_state = S_RESP;
                end else if (q_size == SZ_WORD) begin
                    st_en_raw  = 1'b1;
                    st_data    = q_wdata;
                    next_state = S_RESP;
                end else begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                st_en_raw  = 1'b1;
                st_data    = merge_q;
                next_state = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready_i) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Request capture, load result / merge word registration
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_we    <= 1'b0;
            q_lane  <= 2'b00;
            q_size  <= SZ_BYTE;
            q_uns   <= 1'b0;
            q_err   <= 1'b0;
            q_wdata <= '0;
            addr_q  <= '0;
            merge_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        q_we    <= req_we_i;
                        q_lane  <= cap_addr[1:0];
                        q_size  <= cap_size;
                        q_uns   <= req_unsigned_i;
                        q_err   <= cap_err;
                        q_wdata <= req_wdata_i;
                        addr_q  <= cap_addr[ADDR+1:2];
                    end
                end
                S_ACCESS: begin
                    rdata_q <= (!q_err && !q_we) ? ld_ext : '0;
                    err_q   <= q_err;
                    merge_q <= merge;
                end
                default: ;
            endcase
        end
    end

    assign req_ready_o    = (state == S_IDLE) && !rst_i;
    assign rsp_valid_o    = (state == S_RESP);
    assign rsp_rdata_o    = rdata_q;
    assign rsp_err_o      = err_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_st_en_o   = st_en_raw && !rst_i;
    assign dmem_st_data_o = rst_i ? '0 : st_data;
    assign dbg_state_o    = state;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed bench for dmem_lsu with a request-level memory model.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [11:0] req_addr = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  dmem_addr;
    logic [31:0] dmem_st_data;
    logic        dmem_st_en;
    logic [31:0] dmem_ld_data;
    logic [1:0]  dbg_state;

    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_q [$];
    logic [31:0] err_q [$];
    int          checks = 0;
    int          errors = 0;
    int          wr_count = 0;

    dmem_lsu #(.N(32), .ADDR(10)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_addr_i(req_addr), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
        .dmem_addr_o(dmem_addr), .dmem_st_data_o(dmem_st_data),
        .dmem_st_en_o(dmem_st_en), .dmem_ld_data_i(dmem_ld_data),
        .dbg_state_o(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Word-wide data memory: combinational read, write on the enabled edge
    assign dmem_ld_data = mem[dmem_addr];
    always @(posedge clk) begin
        if (dmem_st_en) begin
            mem[dmem_addr] <= dmem_st_data;
            wr_count <= wr_count + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Request-level model: byte-addressed little-endian memory
    task automatic model_req(input logic we, input logic [11:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata,
                             output logic [31:0] rd, output logic err,
                             output int lat, output int nwr);
        int sz, a, sh;
        logic [31:0] w, mask, v;
        sz  = (size == 2'd3) ? 4 : (1 << size);
        a   = int'(addr);
        err = 1'b0;
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        if (size == 2'd3 || (a % sz) != 0) err = 1'b1;
`else
        a = a - (a % sz);
`endif
        rd = '0; lat = 1; nwr = 0;
        if (err) return;
        w    = ref_mem[a / 4];
        sh   = 8 * (a % 4);
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        if (!we) begin
            v = (w >> sh) & mask;
            if (!uns && sz < 4 && v[8*sz-1]) v = v | ~mask;
            rd = v;
        end else begin
            ref_mem[a / 4] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
            nwr = 1;
            lat = (sz == 4) ? 1 : 2;
        end
    endtask

    // Drive one request, check latency, optional stall, write count
    task automatic do_req(input logic we, input logic [11:0] addr, input logic [1:0] size,
                          input logic uns, input logic [31:0] wdata, input int hold,
                          input logic use_lit, input logic [31:0] lit);
        logic [31:0] er;
        logic        ee;
        int          elat, enwr, n, wr0;
        model_req(we, addr, size, uns, wdata, er, ee, elat, enwr);
        if (use_lit) chk("model_pin", er, lit);
        exp_q.push_back(er);
        err_q.push_back({31'h0, ee});
        @(negedge clk);
        wr0 = wr_count;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        chk("req_ready_idle", {31'h0, req_ready}, 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(posedge clk); #1; n++; end
        chk("rsp_latency", n, elat);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", {31'h0, rsp_valid}, 32'd1);
            chk("stall_rdata", rsp_rdata, er);
            chk("stall_req_ready", {31'h0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        chk("write_count", wr_count - wr0, enwr);
    endtask

    // Compare process: response contents on every handshake, no write under reset
    always @(negedge clk) begin
        if (rsp_valid && rsp_ready && !rst) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rsp_unexpected actual=%h expected=none", rsp_rdata);
            end else begin
                chk("rsp_rdata", rsp_rdata, exp_q.pop_front());
                chk("rsp_err", {31'h0, rsp_err}, err_q.pop_front());
            end
        end
        if (rst && dmem_st_en) chk("st_en_in_reset", {31'h0, dmem_st_en}, 32'd0);
    end

    initial begin
        logic [31:0] w8_before;
        int wr_before;
        for (int i = 0; i < 1024; i++) begin mem[i] = '0; ref_mem[i] = '0; end

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", {31'h0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", {31'h0, rsp_err}, 32'd0);
        chk("rst_dmem_addr", {22'h0, dmem_addr}, 32'd0);
        chk("rst_st_data", dmem_st_data, 32'd0);
        chk("rst_st_en", {31'h0, dmem_st_en}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        #1 chk("post_rst_req_ready", {31'h0, req_ready}, 32'd1);

        // Word store / load
        do_req(1, 12'h010, 2'd2, 0, 32'hDEADBEEF, 0, 1, 32'h0);
        chk("mem_word4", mem[4], 32'hDEADBEEF);
        do_req(0, 12'h010, 2'd2, 0, 32'h0, 0, 1, 32'hDEADBEEF);
        // Byte lane read-modify-write
        do_req(1, 12'h020, 2'd2, 0, 32'h11223344, 0, 1, 32'h0);
        do_req(1, 12'h021, 2'd0, 0, 32'h000000AA, 0, 1, 32'h0);
        do_req(0, 12'h021, 2'd0, 0, 32'h0, 0, 1, 32'hFFFFFFAA);
        do_req(0, 12'h021, 2'd0, 1, 32'h0, 0, 1, 32'h000000AA);
        do_req(0, 12'h020, 2'd2, 0, 32'h0, 0, 1, 32'h1122AA44);
        // Half store / signed load with a 5-cycle response stall
        do_req(1, 12'h022, 2'd1, 0, 32'h00008001, 0, 1, 32'h0);
        do_req(0, 12'h022, 2'd1, 0, 32'h0, 5, 1, 32'hFFFF8001);
        do_req(0, 12'h020, 2'd2, 0, 32'h0, 0, 1, 32'h8001AA44);
        do_req(0, 12'h022, 2'd1, 1, 32'h0, 0, 1, 32'h00008001);
        // Every byte lane of word 8, signed
        for (int k = 0; k < 4; k++) do_req(0, 12'h020 + 12'(k), 2'd0, 0, 32'h0, 0, 0, 32'h0);
        // Top word address
        do_req(1, 12'hFFC, 2'd2, 0, 32'hCAFEF00D, 0, 1, 32'h0);
        do_req(0, 12'hFFF, 2'd0, 0, 32'h0, 0, 1, 32'hFFFFFFCA);
        // Misaligned and illegal-size requests
`ifdef DMEM_LSU_ALIGN_CHECK_EN
        do_req(0, 12'h013, 2'd2, 0, 32'h0, 0, 1, 32'h0);
        do_req(0, 12'h010, 2'd3, 0, 32'h0, 0, 1, 32'h0);
`else
        do_req(0, 12'h013, 2'd2, 0, 32'h0, 0, 1, 32'hDEADBEEF);
        do_req(0, 12'h010, 2'd3, 0, 32'h0, 0, 1, 32'hDEADBEEF);
`endif
        do_req(1, 12'h023, 2'd1, 0, 32'h00001234, 0, 0, 32'h0);
        do_req(0, 12'h020, 2'd2, 0, 32'h0, 0, 0, 32'h0);

        // Reset during the WRITE cycle of a byte store
        w8_before = ref_mem[8];
        @(negedge clk);
        wr_before = wr_count;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 12'h020; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'h00000055;
        @(posedge clk); #1 req_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1 chk("rst_write_st_en", {31'h0, dmem_st_en}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        #1;
        chk("after_rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
        chk("after_rst_req_ready", {31'h0, req_ready}, 32'd1);
        @(posedge clk); #1;
        chk("rst_no_write", wr_count - wr_before, 32'd0);
        chk("rst_word_unchanged", mem[8], w8_before);

        // Final memory image against the model
        chk("mem_word4_final", mem[4], ref_mem[4]);
        chk("mem_word8_final", mem[8], ref_mem[8]);
        chk("mem_word1023_final", mem[1023], ref_mem[1023]);
        chk("model_word1023_pin", ref_mem[1023], 32'hCAFEF00D);
        chk("exp_q_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end

endmodule
